// File: rtl/bitserial_logic_unit.sv
// Multi-cycle bitwise logic unit: AND/OR/XOR/NOT on WIDTH-bit operands, LANE bits per clock.
// Optional ZERO_FLAG_EN macro adds a registered result==0 flag; otherwise zero_o is tied low.
module bitserial_logic_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANE  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    localparam int unsigned N  = WIDTH / LANE;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept_c;
    logic             last_c;
    logic [LANE-1:0]  slice_c;
    logic [WIDTH+LANE-1:0] res_cat_c;

    assign accept_c = (state_q == S_IDLE) && start_i;
    assign last_c   = (cnt_q == CW'(N - 1));

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (last_c)  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode, registered below so busy/done line up with the state they describe
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_RUN:   busy_d = 1'b1;
            S_DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // One slice of the selected operation on the low LANE bits
    always_comb begin
        slice_c = '0;
        case (op_q)
            OP_AND:  slice_c = a_sh_q[LANE-1:0] & b_sh_q[LANE-1:0];
            OP_OR:   slice_c = a_sh_q[LANE-1:0] | b_sh_q[LANE-1:0];
            OP_XOR:  slice_c = a_sh_q[LANE-1:0] ^ b_sh_q[LANE-1:0];
            default: slice_c = ~a_sh_q[LANE-1:0];
        endcase
    end

    // New slice enters at the top; the concatenation keeps LANE == WIDTH well-formed
    assign res_cat_c = {slice_c, res_sh_q};

    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        res_sh_d = res_sh_q;
        result_d = result_q;
        if (accept_c) begin
            a_sh_d   = a_i;
            b_sh_d   = b_i;
            op_d     = op_i;
            cnt_d    = '0;
            res_sh_d = '0;
        end else if (state_q == S_RUN) begin
            a_sh_d   = a_sh_q >> LANE;
            b_sh_d   = b_sh_q >> LANE;
            res_sh_d = res_cat_c[WIDTH+LANE-1:LANE];
            cnt_d    = cnt_q + CW'(1);
            if (last_c) begin
                result_d = res_sh_d;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            res_sh_q <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            res_sh_q <= res_sh_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

`ifdef ZERO_FLAG_EN
    logic zero_q, zero_d;

    // Flag tracks the result register: updated only when a new result lands
    always_comb begin
        zero_d = zero_q;
        if ((state_q == S_RUN) && last_c && !accept_c) begin
            zero_d = (res_sh_d == '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign zero_o = zero_q;
`else
    assign zero_o = 1'b0;
`endif

endmodule

// File: tb/tb_bitserial_logic_unit.sv
// Bench for bitserial_logic_unit: three WIDTH=8 instances (LANE 1, 4, 8) against a word-level model.
`timescale 1ns/1ps
module tb_bitserial_logic_unit;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start;
    logic [1:0] op;
    logic [7:0] a, b;
    logic [2:0] busy, done, zero;
    logic [7:0] res [NDUT];

    logic [7:0] prev_res  [NDUT];
    logic       prev_zero [NDUT];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        bitserial_logic_unit #(
            .WIDTH(8),
            .LANE ((g == 0) ? 1 : (g == 1) ? 4 : 8)
        ) u_dut (
            .clk_i   (clk),
            .rst_i   (rst),
            .start_i (start[g]),
            .op_i    (op),
            .a_i     (a),
            .b_i     (b),
            .busy_o  (busy[g]),
            .done_o  (done[g]),
            .result_o(res[g]),
            .zero_o  (zero[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~x;
        endcase
    endfunction

    function automatic logic zmodel(input logic [7:0] r);
`ifdef ZERO_FLAG_EN
        return (r == 8'h00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int nslices(input int g);
        return (g == 0) ? 8 : (g == 1) ? 2 : 1;
    endfunction

    task automatic check_idle_zero(input string tag);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("%s busy[%0d]", tag, g), 32'(busy[g]), 32'd0);
            check($sformatf("%s done[%0d]", tag, g), 32'(done[g]), 32'd0);
            check($sformatf("%s result[%0d]", tag, g), 32'(res[g]), 32'd0);
            check($sformatf("%s zero[%0d]", tag, g), 32'(zero[g]), 32'd0);
            prev_res[g]  = 8'h00;
            prev_zero[g] = 1'b0;
        end
    endtask

    // Start all three units together; optionally poke unit 0 with a stray start or reset mid-flight
    task automatic run_op(input logic [1:0] o, input logic [7:0] aa, input logic [7:0] bb,
                          input int restart_at, input int abort_at);
        logic [7:0] exp;
        exp = model(o, aa, bb);
        @(negedge clk);
        a = aa; b = bb; op = o; start = 3'b111;
        @(posedge clk);
        @(negedge clk);
        start = 3'b000;
        a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            for (int g = 0; g < NDUT; g++) begin
                int n;
                n = nslices(g);
                check($sformatf("op%0d k%0d done[%0d]", o, k, g), 32'(done[g]), 32'(k == n));
                check($sformatf("op%0d k%0d busy[%0d]", o, k, g), 32'(busy[g]), 32'(k <= n));
                check($sformatf("op%0d k%0d result[%0d]", o, k, g), 32'(res[g]),
                      32'((k >= n) ? exp : prev_res[g]));
                check($sformatf("op%0d k%0d zero[%0d]", o, k, g), 32'(zero[g]),
                      32'((k >= n) ? zmodel(exp) : prev_zero[g]));
            end
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                check_idle_zero("async reset");
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            start[0] = (k + 1 == restart_at);
            a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
        end
        start = 3'b000;
        for (int g = 0; g < NDUT; g++) begin
            prev_res[g]  = exp;
            prev_zero[g] = zmodel(exp);
        end
    endtask

    // Start held high on the LANE=4 unit: back-to-back ops every N+2 edges
    task automatic run_held();
        logic [1:0] ops [3];
        logic [7:0] as  [3];
        logic [7:0] bs  [3];
        logic [7:0] rs  [3];
        ops[0] = 2'b00; as[0] = 8'hF0; bs[0] = 8'h0F;
        ops[1] = 2'b10; as[1] = 8'h81; bs[1] = 8'h81;
        ops[2] = 2'b01; as[2] = 8'h81; bs[2] = 8'h81;
        for (int i = 0; i < 3; i++) rs[i] = model(ops[i], as[i], bs[i]);
        @(negedge clk);
        a = as[0]; b = bs[0]; op = ops[0]; start = 3'b010;
        for (int k = 0; k <= 11; k++) begin
            int ph, idx;
            logic [7:0] er;
            @(posedge clk);
            @(negedge clk);
            ph  = k % 4;
            idx = k / 4;
            er  = (ph >= 2) ? rs[idx] : (idx == 0) ? prev_res[1] : rs[idx-1];
            check($sformatf("held k%0d done", k), 32'(done[1]), 32'(ph == 2));
            check($sformatf("held k%0d busy", k), 32'(busy[1]), 32'(ph != 3));
            check($sformatf("held k%0d result", k), 32'(res[1]), 32'(er));
            check($sformatf("held k%0d zero", k), 32'(zero[1]),
                  32'(((ph < 2) && (idx == 0)) ? prev_zero[1] : zmodel(er)));
            if (ph == 0 && idx < 2) begin
                a = as[idx+1]; b = bs[idx+1]; op = ops[idx+1];
            end
            if (k == 8) start = 3'b000;
        end
        prev_res[1]  = rs[2];
        prev_zero[1] = zmodel(rs[2]);
    endtask

    initial begin
        rst = 1'b1; start = 3'b000; a = 8'h00; b = 8'h00; op = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;

        run_op(2'b00, 8'hF0, 8'hCC, 0, -1);
        run_op(2'b10, 8'hA5, 8'h0F, 0, -1);
        run_op(2'b01, 8'hA5, 8'h0F, 0, -1);
        run_op(2'b11, 8'h3C, 8'hFF, 0, -1);
        run_op(2'b00, 8'hFF, 8'h0F, 3, -1);
        run_op(2'b01, 8'h12, 8'h34, 0, 3);
        run_op(2'b00, 8'h0F, 8'h0F, 0, -1);
        run_op(2'b10, 8'h5A, 8'h5A, 0, -1);
        for (int i = 0; i < 20; i++) begin
            run_op(2'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(2, 7)), -1);
        end
        run_held();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
